// File: rtl/cache_tag_lookup.sv
// cache_tag_lookup: multi-cycle tag lookup for one set of a set-associative cache.
// The set is scanned LANES ways per cycle. Each group's compare result is
// registered before the scan decides to stop, so a hit in group g is reported
// g+2 edges after acceptance and a miss NGRP+1 edges after acceptance.
// The lowest-index valid matching way wins. On a miss, the lowest-index invalid
// way seen during the scan is reported as a free way.
// Optional feature macro: CACHE_MULTIHIT_CHK_EN. When it is defined, every group
// is always scanned and rsp_multihit flags two or more valid matches. When it is
// undefined, the scan stops at the first hit and rsp_multihit is tied to 0.
module cache_tag_lookup #(
    parameter int  WAYS  = 8,
    parameter int  TAG_W = 12,
    parameter int  LANES = 2,
    localparam int WAY_W = $clog2(WAYS),
    localparam int NGRP  = WAYS / LANES
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [TAG_W-1:0]      req_tag,
    input  logic [WAYS*TAG_W-1:0] set_tags,
    input  logic [WAYS-1:0]       set_valid,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic [WAY_W-1:0]      rsp_way,
    output logic                  rsp_free_valid,
    output logic [WAY_W-1:0]      rsp_free_way,
    output logic                  rsp_multihit
);

    localparam int               GRP_W    = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NGRP - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state_q, state_d;
    logic [GRP_W-1:0]   grp_q, grp_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               last_q, last_d;
    logic               hit_found_q, hit_found_d;
    logic [WAY_W-1:0]   hit_way_q, hit_way_d;
    logic               free_found_q, free_found_d;
    logic [WAY_W-1:0]   free_way_q, free_way_d;
    logic               rsp_hit_q, rsp_hit_d;
    logic [WAY_W-1:0]   rsp_way_q, rsp_way_d;
    logic               rsp_free_valid_q, rsp_free_valid_d;
    logic [WAY_W-1:0]   rsp_free_way_q, rsp_free_way_d;

    logic               grp_hit;
    logic [WAY_W-1:0]   grp_way;
    logic               grp_free;
    logic [WAY_W-1:0]   grp_free_way;
    logic [WAY_W-1:0]   lane_way;
    logic               finish;

`ifdef CACHE_MULTIHIT_CHK_EN
    logic [1:0]         grp_cnt;
    logic               multi_q, multi_d;
    logic               rsp_multihit_q, rsp_multihit_d;
`endif

    logic [TAG_W-1:0]   way_tag [WAYS];

    for (genvar w = 0; w < WAYS; w++) begin : g_unpack
        assign way_tag[w] = set_tags[w*TAG_W +: TAG_W];
    end

    // Compare the current group: lowest matching way, lowest invalid way, match count.
    always_comb begin
        grp_hit      = 1'b0;
        grp_way      = '0;
        grp_free     = 1'b0;
        grp_free_way = '0;
        lane_way     = '0;
`ifdef CACHE_MULTIHIT_CHK_EN
        grp_cnt      = 2'd0;
`endif
        for (int l = 0; l < LANES; l++) begin
            lane_way = WAY_W'(int'(grp_q) * LANES + l);
            if (set_valid[lane_way] && (way_tag[lane_way] == tag_q)) begin
                if (!grp_hit) begin
                    grp_hit = 1'b1;
                    grp_way = lane_way;
                end
`ifdef CACHE_MULTIHIT_CHK_EN
                if (grp_cnt != 2'd2) begin
                    grp_cnt = grp_cnt + 2'd1;
                end
`endif
            end
            if (!set_valid[lane_way] && !grp_free) begin
                grp_free     = 1'b1;
                grp_free_way = lane_way;
            end
        end
    end

    // Next-state and datapath: accept, scan group by group, then hold the result.
    always_comb begin
        state_d          = state_q;
        grp_d            = grp_q;
        tag_d            = tag_q;
        last_d           = last_q;
        hit_found_d      = hit_found_q;
        hit_way_d        = hit_way_q;
        free_found_d     = free_found_q;
        free_way_d       = free_way_q;
        rsp_hit_d        = rsp_hit_q;
        rsp_way_d        = rsp_way_q;
        rsp_free_valid_d = rsp_free_valid_q;
        rsp_free_way_d   = rsp_free_way_q;
`ifdef CACHE_MULTIHIT_CHK_EN
        multi_d          = multi_q;
        rsp_multihit_d   = rsp_multihit_q;
        finish           = last_q;
`else
        finish           = last_q || hit_found_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d      = SCAN;
                    tag_d        = req_tag;
                    grp_d        = '0;
                    last_d       = 1'b0;
                    hit_found_d  = 1'b0;
                    hit_way_d    = '0;
                    free_found_d = 1'b0;
                    free_way_d   = '0;
`ifdef CACHE_MULTIHIT_CHK_EN
                    multi_d      = 1'b0;
`endif
                end
            end
            SCAN: begin
                if (finish) begin
                    state_d          = DONE;
                    rsp_hit_d        = hit_found_q;
                    rsp_way_d        = hit_found_q ? hit_way_q : '0;
                    rsp_free_valid_d = !hit_found_q && free_found_q;
                    rsp_free_way_d   = (!hit_found_q && free_found_q) ? free_way_q : '0;
`ifdef CACHE_MULTIHIT_CHK_EN
                    rsp_multihit_d   = multi_q;
`endif
                end else begin
                    if (grp_hit && !hit_found_q) begin
                        hit_found_d = 1'b1;
                        hit_way_d   = grp_way;
                    end
                    if (grp_free && !free_found_q) begin
                        free_found_d = 1'b1;
                        free_way_d   = grp_free_way;
                    end
`ifdef CACHE_MULTIHIT_CHK_EN
                    multi_d = multi_q || (grp_cnt == 2'd2) || ((grp_cnt != 2'd0) && hit_found_q);
`endif
                    last_d = (grp_q == LAST_GRP);
                    if (grp_q != LAST_GRP) begin
                        grp_d = grp_q + GRP_W'(1);
                    end
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan bookkeeping and response registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            grp_q            <= '0;
            tag_q            <= '0;
            last_q           <= 1'b0;
            hit_found_q      <= 1'b0;
            hit_way_q        <= '0;
            free_found_q     <= 1'b0;
            free_way_q       <= '0;
            rsp_hit_q        <= 1'b0;
            rsp_way_q        <= '0;
            rsp_free_valid_q <= 1'b0;
            rsp_free_way_q   <= '0;
`ifdef CACHE_MULTIHIT_CHK_EN
            multi_q          <= 1'b0;
            rsp_multihit_q   <= 1'b0;
`endif
        end else begin
            grp_q            <= grp_d;
            tag_q            <= tag_d;
            last_q           <= last_d;
            hit_found_q      <= hit_found_d;
            hit_way_q        <= hit_way_d;
            free_found_q     <= free_found_d;
            free_way_q       <= free_way_d;
            rsp_hit_q        <= rsp_hit_d;
            rsp_way_q        <= rsp_way_d;
            rsp_free_valid_q <= rsp_free_valid_d;
            rsp_free_way_q   <= rsp_free_way_d;
`ifdef CACHE_MULTIHIT_CHK_EN
            multi_q          <= multi_d;
            rsp_multihit_q   <= rsp_multihit_d;
`endif
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign rsp_valid      = (state_q == DONE);
    assign rsp_hit        = rsp_hit_q;
    assign rsp_way        = rsp_way_q;
    assign rsp_free_valid = rsp_free_valid_q;
    assign rsp_free_way   = rsp_free_way_q;
`ifdef CACHE_MULTIHIT_CHK_EN
    assign rsp_multihit   = rsp_multihit_q;
`else
    assign rsp_multihit   = 1'b0;
`endif

endmodule
